controller_hub: RTL and testbench

Parametrised multi-player input conditioner that replaces the per-player `controller` instances feeding `game`. It takes raw joystick/button pins for `NUM_PLAYERS` players and produces a clean per-player control word. Each pin is synchronised, polarity-normalised and debounced. Opposing directions are resolved by a selectable SOCD policy, and a one-cycle attack-press pulse is generated. Output words are packed so that player p's word drives `game` at `p*7`.

---
 rtl/controller_hub.sv | 129 ++++++++++++
 tb/tb_controller_hub.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller_hub.sv
// rtl/controller_hub.sv - per-player input synchroniser, debouncer, SOCD resolver and press-pulse generator
module controller_hub #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
    parameter int SOCD_MODE       = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PLAYERS-1:0]   left_l,
    input  logic [NUM_PLAYERS-1:0]   right_l,
    input  logic [NUM_PLAYERS-1:0]   up_l,
    input  logic [NUM_PLAYERS-1:0]   down_l,
    input  logic [NUM_PLAYERS-1:0]   attack,
    input  logic [NUM_PLAYERS-1:0]   shield,
    output logic [7*NUM_PLAYERS-1:0] controller_inputs,
    output logic [6*NUM_PLAYERS-1:0] press
);

    localparam int NCH  = 6 * NUM_PLAYERS;
    localparam int NAX  = 2 * NUM_PLAYERS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LAST_NONE,
        LAST_A,
        LAST_B
    } last_t;

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   stable;
    logic [NCH-1:0]   stable_q;
    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   fall;
    logic [NCH-1:0]   resolved;
    logic [CNT_W-1:0] cnt [NCH];
    last_t            last [NAX];
    last_t            last_next [NAX];

    // Channel order within a player: left, right, up, down, attack, shield; 1 = pressed
    always_comb begin
        raw = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            raw[6*p +: 6] = {shield[p], attack[p], ~down_l[p], ~up_l[p], ~right_l[p], ~left_l[p]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_q <= stable;
            for (int i = 0; i < NCH; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = stable & ~stable_q;
    assign fall = ~stable & stable_q;

    // Axis 0 is left(A)/right(B), axis 1 is up(A)/down(B). The output uses the
    // next-state of last so a late press wins on the same cycle it is seen.
    always_comb begin
        resolved = stable;
        for (int k = 0; k < NAX; k++) begin
            last_next[k] = last[k];
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int ax = 0; ax < 2; ax++) begin
                if (fall[6*p+2*ax] || fall[6*p+2*ax+1]) begin
                    last_next[2*p+ax] = LAST_NONE;
                end else if (rise[6*p+2*ax] && rise[6*p+2*ax+1]) begin
                    last_next[2*p+ax] = LAST_NONE;
                end else if (rise[6*p+2*ax] && stable[6*p+2*ax+1]) begin
                    last_next[2*p+ax] = LAST_A;
                end else if (rise[6*p+2*ax+1] && stable[6*p+2*ax]) begin
                    last_next[2*p+ax] = LAST_B;
                end
                if (stable[6*p+2*ax] && stable[6*p+2*ax+1]) begin
                    resolved[6*p+2*ax]   = (SOCD_MODE == 1) && (last_next[2*p+ax] == LAST_A);
                    resolved[6*p+2*ax+1] = (SOCD_MODE == 1) && (last_next[2*p+ax] == LAST_B);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NAX; k++) begin
                last[k] <= LAST_NONE;
            end
        end else begin
            for (int k = 0; k < NAX; k++) begin
                last[k] <= last_next[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            controller_inputs <= '0;
            press             <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                controller_inputs[7*p +: 7] <= {rise[6*p+4], resolved[6*p +: 6]};
            end
            press <= rise;
        end
    end

endmodule

// File: tb/tb_controller_hub.sv
// tb/tb_controller_hub.sv - self-checking bench for controller_hub (neutral and last-wins instances)
module tb_controller_hub;

    localparam int NP = 4;
    localparam int D  = 4;
    localparam int NC = 6 * NP;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   left_l, right_l, up_l, down_l, attack, shield;
    logic [7*NP-1:0] ci0, ci1;
    logic [6*NP-1:0] pr0, pr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controller_hub #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(D), .CNT_W(2), .SOCD_MODE(0)) dut0 (
        .clk(clk), .reset(reset),
        .left_l(left_l), .right_l(right_l), .up_l(up_l), .down_l(down_l),
        .attack(attack), .shield(shield),
        .controller_inputs(ci0), .press(pr0)
    );

    controller_hub #(.NUM_PLAYERS(NP), .DEBOUNCE_CYCLES(D), .CNT_W(2), .SOCD_MODE(1)) dut1 (
        .clk(clk), .reset(reset),
        .left_l(left_l), .right_l(right_l), .up_l(up_l), .down_l(down_l),
        .attack(attack), .shield(shield),
        .controller_inputs(ci1), .press(pr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a button's accepted level flips once the value seen two edges
    // after the pin has differed from it for D consecutive edges. Last-wins
    // picks whichever held direction was accepted more recently.
    logic [NC-1:0] m_d1, m_d2, m_acc, m_acc_q, m_run_val;
    int            m_run_len [NC];
    int            m_ts [NC];
    int            edge_no = 0;
    bit            model_on = 1'b0;

    function automatic logic [7*NP-1:0] exp_word(input int mode);
        logic [7*NP-1:0] w;
        w = '0;
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < 6; i++) w[7*p+i] = m_acc[6*p+i];
            for (int ax = 0; ax < 2; ax++) begin
                if (m_acc[6*p+2*ax] && m_acc[6*p+2*ax+1]) begin
                    w[7*p+2*ax]   = (mode == 1) && (m_ts[6*p+2*ax] > m_ts[6*p+2*ax+1]);
                    w[7*p+2*ax+1] = (mode == 1) && (m_ts[6*p+2*ax+1] > m_ts[6*p+2*ax]);
                end
            end
            w[7*p+6] = m_acc[6*p+4] & ~m_acc_q[6*p+4];
        end
        return w;
    endfunction

    initial begin
        logic          rst_s;
        logic [NC-1:0] raw_s, old_acc;
        logic [7*NP-1:0] e_ci0, e_ci1;
        logic [NC-1:0] e_pr;
        forever begin
            @(posedge clk);
            rst_s = reset;
            for (int p = 0; p < NP; p++)
                raw_s[6*p +: 6] = {shield[p], attack[p], ~down_l[p], ~up_l[p], ~right_l[p], ~left_l[p]};
            #1;
            edge_no++;
            if (rst_s === 1'b1) begin
                model_on = 1'b1;
                m_d1 = '0; m_d2 = '0; m_acc = '0; m_acc_q = '0; m_run_val = '0;
                for (int c = 0; c < NC; c++) begin
                    m_run_len[c] = 0;
                    m_ts[c] = 0;
                end
                e_ci0 = '0; e_ci1 = '0; e_pr = '0;
            end else begin
                e_ci0 = exp_word(0);
                e_ci1 = exp_word(1);
                e_pr  = m_acc & ~m_acc_q;
                old_acc = m_acc;
                for (int c = 0; c < NC; c++) begin
                    if (m_d2[c] == m_run_val[c]) m_run_len[c]++;
                    else begin
                        m_run_val[c] = m_d2[c];
                        m_run_len[c] = 1;
                    end
                    if (m_run_val[c] != m_acc[c] && m_run_len[c] >= D) m_acc[c] = m_run_val[c];
                    if (m_acc[c] && !old_acc[c]) m_ts[c] = edge_no;
                end
                m_acc_q = old_acc;
                m_d2 = m_d1;
                m_d1 = raw_s;
            end
            if (model_on) begin
                check("model ci neutral", ci0, e_ci0);
                check("model ci lastwin", ci1, e_ci1);
                check("model press neutral", pr0, e_pr);
                check("model press lastwin", pr1, e_pr);
            end
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        left_l = '1; right_l = '1; up_l = '1; down_l = '1;
        attack = '0; shield = '0;
        wait_edges(3);
        check("reset ci", ci0, 0);
        check("reset press", pr0, 0);
        @(negedge clk) reset = 1'b0;
        wait_edges(8);
        check("idle ci", ci0, 0);

        // latency and pulse width
        @(negedge clk) left_l[0] = 1'b0;
        wait_edges(6);
        check("latency pre ci[0]", ci0[0], 0);
        wait_edges(1);
        check("latency ci[0]", ci0[0], 1);
        check("latency press[0]", pr0[0], 1);
        wait_edges(1);
        check("pulse width press[0]", pr0[0], 0);
        @(negedge clk) left_l[0] = 1'b1;
        wait_edges(7);
        check("release ci[0]", ci0[0], 0);
        check("release press", pr0, 0);

        // bounce rejection on attack[1]
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            attack[1] = ~attack[1];
            repeat (3) @(negedge clk);
        end
        check("bounce ci[11]", ci0[11], 0);
        attack[1] = 1'b1;
        wait_edges(6);
        check("bounce pre ci[11]", ci0[11], 0);
        wait_edges(1);
        check("bounce ci[11] held", ci0[11], 1);
        check("bounce ci[13] pulse", ci0[13], 1);
        check("bounce press[10]", pr0[10], 1);
        @(negedge clk) attack[1] = 1'b0;
        wait_edges(10);

        // SOCD: left then right
        @(negedge clk) left_l[0] = 1'b0;
        wait_edges(10);
        @(negedge clk) right_l[0] = 1'b0;
        wait_edges(7);
        check("neutral both", ci0[1:0], 2'b00);
        check("lastwin right", ci1[1:0], 2'b10);
        @(negedge clk) right_l[0] = 1'b1;
        wait_edges(6);
        check("lastwin pre release", ci1[1:0], 2'b10);
        wait_edges(1);
        check("lastwin left only", ci1[1:0], 2'b01);
        check("neutral left only", ci0[1:0], 2'b01);
        @(negedge clk) right_l[0] = 1'b0;
        wait_edges(7);
        check("lastwin right again", ci1[1:0], 2'b10);
        check("neutral both again", ci0[1:0], 2'b00);
        @(negedge clk) left_l[0] = 1'b1;
        wait_edges(7);
        check("neutral right only", ci0[1:0], 2'b10);
        @(negedge clk) right_l[0] = 1'b1;
        wait_edges(10);
        @(negedge clk) begin
            left_l[0] = 1'b0;
            right_l[0] = 1'b0;
        end
        wait_edges(7);
        check("same edge press", pr1[1:0], 2'b11);
        check("same edge lastwin", ci1[1:0], 2'b00);
        check("same edge neutral", ci0[1:0], 2'b00);
        @(negedge clk) begin
            left_l[0] = 1'b1;
            right_l[0] = 1'b1;
        end
        wait_edges(10);

        // reset mid-debounce
        @(negedge clk) shield[2] = 1'b1;
        wait_edges(10);
        check("shield2 held", ci0[19], 1);
        @(negedge clk) up_l[0] = 1'b0;
        wait_edges(2);
        @(negedge clk) reset = 1'b1;
        wait_edges(1);
        check("mid reset ci", ci0, 0);
        check("mid reset ci lastwin", ci1, 0);
        @(negedge clk) reset = 1'b0;
        wait_edges(6);
        check("post reset pre up", ci0[2], 0);
        wait_edges(1);
        check("post reset up", ci0[2], 1);
        check("post reset shield2", ci0[19], 1);
        check("post reset press up", pr0[2], 1);
        @(negedge clk) begin
            up_l[0] = 1'b1;
            shield[2] = 1'b0;
        end
        wait_edges(10);

        // scaling: player 3 shield only
        @(negedge clk) shield[3] = 1'b1;
        wait_edges(7);
        check("scale ci", ci0, 32'h0400_0000);
        check("scale press", pr0, 32'h0080_0000);
        check("scale ci lastwin", ci1, 32'h0400_0000);
        @(negedge clk) shield[3] = 1'b0;
        wait_edges(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
